riscv_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit, directly downstream of the op1/op2 operand muxes.
- Consumes the selected op1 (rs1 or pc path) and op2 when the decoded instruction is an M-extension op.
- Produces a WORD_LENGTH result for writeback.
- Multi-cycle, with a start/busy/done handshake; the pipeline stalls on busy.

---
 rtl/riscv_muldiv.sv | 196 +++++++++++++++++++
 tb/tb_riscv_muldiv.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv.sv
// riscv_muldiv - iterative RV32M multiply/divide unit.
//
// Sits after the op1/op2 operand muxes. An op is accepted in IDLE when start
// is high. busy stays high until the op completes, and done pulses for one
// cycle when result is valid. The pipeline stalls while busy is high.
//
// Ports:
//   clk     - clock; all state changes on the rising edge
//   rst     - synchronous active-high reset
//   start   - request a new operation; only sampled in IDLE
//   funct3  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM,    111 REMU
//   op1     - first operand (dividend / multiplicand)
//   op2     - second operand (divisor / multiplier)
//   flush   - abort any in-flight op; no done pulse, result left unchanged
//   busy    - high while an accepted op is in flight
//   done    - one-cycle pulse; result valid in the same cycle
//   result  - WORD_LENGTH result; holds its value until the next done
//
// Build option:
//   RISCV_MULDIV_FASTMUL_EN - when defined, multiplies use a single-cycle
//   combinational product (done one cycle after start). Divides are always
//   iterative.

module riscv_muldiv #(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             funct3,
  input  logic [WORD_LENGTH-1:0] op1,
  input  logic [WORD_LENGTH-1:0] op2,
  input  logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] result
);

  localparam int unsigned W  = WORD_LENGTH;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2:0]     op_q;     // latched funct3
  logic           neg_q;    // negate the final word
  logic [W-1:0]   opnd_q;   // multiplicand magnitude, or divisor magnitude
  logic [2*W-1:0] acc_q;    // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]  cnt_q;

  // Two's-complement a full product when needed, then pick the low word for
  // MUL or the high word for the MULH variants.
  function automatic logic [W-1:0] mul_select(input logic [2*W-1:0] p,
                                               input logic           neg,
                                               input logic [1:0]     f);
    logic [2*W-1:0] s;
    s = neg ? -p : p;
    return (f == 2'b00) ? s[W-1:0] : s[2*W-1:W];
  endfunction

  // ---------------- operand decode ----------------
  logic           is_div, sg1, sg2, neg1, neg2, neg_flag;
  logic [W-1:0]   mag1, mag2;
  logic           div_zero, div_ovf, special, fast_mul, accept;
  logic [W-1:0]   special_val, fast_val;

  always_comb begin
    is_div = funct3[2];
    sg1    = 1'b0;
    sg2    = 1'b0;
    unique case (funct3)
      3'b001:  begin sg1 = 1'b1; sg2 = 1'b1; end  // MULH
      3'b010:  begin sg1 = 1'b1; sg2 = 1'b0; end  // MULHSU
      3'b100,
      3'b110:  begin sg1 = 1'b1; sg2 = 1'b1; end  // DIV, REM
      default: begin sg1 = 1'b0; sg2 = 1'b0; end  // MUL, MULHU, DIVU, REMU
    endcase
    neg1 = sg1 & op1[W-1];
    neg2 = sg2 & op2[W-1];
    mag1 = neg1 ? -op1 : op1;
    mag2 = neg2 ? -op2 : op2;
    // Remainder takes the dividend's sign; everything else the XOR of signs.
    neg_flag = (funct3 == 3'b110) ? neg1 : (neg1 ^ neg2);

    div_zero = is_div && (op2 == '0);
    div_ovf  = !funct3[0] && is_div && (op1 == MOST_NEG) && (op2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero)
      special_val = funct3[1] ? op1 : '1;
    else
      special_val = funct3[1] ? '0 : op1;
  end

`ifdef RISCV_MULDIV_FASTMUL_EN
  logic [2*W-1:0] fast_prod;
  always_comb begin
    fast_prod = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
    fast_val  = mul_select(fast_prod, neg_flag, funct3[1:0]);
    fast_mul  = !is_div;
  end
`else
  always_comb begin
    fast_val = '0;
    fast_mul = 1'b0;
  end
`endif

  assign accept = (state == IDLE) && start && !flush;

  // ---------------- iteration steps ----------------
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     rem_sh, diff;
  logic [2*W-1:0] div_next;
  logic [W-1:0]   div_word, div_fix, fix_val;

  always_comb begin
    // Shift-add: conditionally add multiplicand to the upper half, shift right.
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};

    // Restoring divide: shift next dividend bit into remainder, trial subtract.
    rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    if (diff[W])
      div_next = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    else
      div_next = {diff[W-1:0], acc_q[W-2:0], 1'b1};

    div_word = op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
    div_fix  = neg_q ? -div_word : div_word;
    fix_val  = op_q[2] ? div_fix : mul_select(acc_q, neg_q, op_q[1:0]);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (special || fast_mul) ? DONE : CALC;
      CALC: if (flush) state_nxt = IDLE;
            else if (cnt_q == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = flush ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_q   <= funct3;
          neg_q  <= neg_flag;
          cnt_q  <= CW'(W);
          opnd_q <= is_div ? mag2 : mag1;
          acc_q  <= {{W{1'b0}}, (is_div ? mag1 : mag2)};
          if (special)       result <= special_val;
          else if (fast_mul) result <= fast_val;
        end
        CALC: if (!flush) begin
          acc_q <= op_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: if (!flush) result <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed bench for riscv_muldiv (WORD_LENGTH = 32).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled on the falling edge. Cycle T is the cycle with start high.

module tb_riscv_muldiv;

  localparam int LONG_LAT = 34;
`ifdef RISCV_MULDIV_FASTMUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = LONG_LAT;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op1, op2;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  riscv_muldiv #(.WORD_LENGTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op1    (op1),
    .op2    (op2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 of cycle T; returns at posedge+1 two cycles after done.
  task automatic run_op(input string name, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic busy_ok;
    start = 1'b1; funct3 = f; op1 = a; op2 = b;
    @(negedge clk);
    check({name, ".idle_busy"}, {31'd0, busy}, 32'd0);
    next_cycle();
    // Scramble the inputs: only the copies latched at T may be used.
    start = 1'b0; funct3 = 3'($urandom); op1 = $urandom; op2 = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      next_cycle();
    end
    check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    check({name, ".result"}, result, exp);
    check({name, ".busy_held"}, {31'd0, busy_ok}, 32'd1);
    next_cycle();
    @(negedge clk);
    check({name, ".idle_after"}, {30'd0, busy, done}, 32'd0);
    next_cycle();
  endtask

  initial begin
    logic [31:0] prior;
    logic        seen, ok;
    int          first_done, n_done;

    vecs.push_back('{"MUL_7x-3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT});
    vecs.push_back('{"MULH_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT});
    vecs.push_back('{"MULH_-1x5",     3'b001, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, MUL_LAT});
    vecs.push_back('{"MULHU_max_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT});
    vecs.push_back('{"MULHU_2^31x4",  3'b011, 32'h80000000, 32'd4,        32'd2,        MUL_LAT});
    vecs.push_back('{"MULHSU_max",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT});
    vecs.push_back('{"DIV_-7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LONG_LAT});
    vecs.push_back('{"REM_-7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LONG_LAT});
    vecs.push_back('{"DIV_100/-7",    3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, LONG_LAT});
    vecs.push_back('{"REM_100/-7",    3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        LONG_LAT});
    vecs.push_back('{"REM_-100/7",    3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, LONG_LAT});
    vecs.push_back('{"DIVU_5/0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{"REM_5/0",       3'b110, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{"DIV_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{"REM_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
    vecs.push_back('{"REMU_100/7",    3'b111, 32'd100,      32'd7,        32'd2,        LONG_LAT});
    vecs.push_back('{"DIVU_100/7",    3'b101, 32'd100,      32'd7,        32'd14,       LONG_LAT});

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op1 = '0; op2 = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.result", result, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    prior = vecs[vecs.size()-1].exp;

    // start together with flush in IDLE is ignored.
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; op1 = 32'd9; op2 = 32'd3;
    next_cycle();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle.busy", {31'd0, busy}, 32'd0);
    next_cycle();

    // DIV 100/7, flush in T+10, a stray start in T+3.
    start = 1'b1; funct3 = 3'b100; op1 = 32'd100; op2 = 32'd7;
    next_cycle();
    start = 1'b0;
    seen = 1'b0; ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      flush = (c == 10);
      if (c == 3) begin
        start = 1'b1; funct3 = 3'b000; op1 = 32'd3; op2 = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
      if (c <= 10 && !busy) ok = 1'b0;
      if (c > 11 && busy) ok = 1'b0;
      if (c == 11) check("flush.busy_T+11", {31'd0, busy}, 32'd0);
      next_cycle();
    end
    flush = 1'b0;
    check("flush.no_done", {31'd0, seen}, 32'd0);
    check("flush.busy_profile", {31'd0, ok}, 32'd1);
    check("flush.result_kept", result, prior);

    // A start while busy is neither accepted nor queued.
    start = 1'b1; funct3 = 3'b101; op1 = 32'd100; op2 = 32'd7;
    next_cycle();
    start = 1'b0;
    first_done = 0; n_done = 0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 5) begin
        start = 1'b1; funct3 = 3'b000; op1 = 32'd3; op2 = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = c;
        check("busy_start.result", result, 32'd14);
      end
      next_cycle();
    end
    check("busy_start.latency", 32'(first_done), 32'(LONG_LAT));
    check("busy_start.done_count", 32'(n_done), 32'd1);

    // Reset in T+5 of a DIV aborts it and clears result.
    start = 1'b1; funct3 = 3'b100; op1 = 32'd100; op2 = 32'd7;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < 5; c++) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midreset.busy_before", {31'd0, busy}, 32'd1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("midreset.busy", {31'd0, busy}, 32'd0);
    check("midreset.done", {31'd0, done}, 32'd0);
    check("midreset.result", result, 32'd0);
    next_cycle();
    run_op("DIVU_9/3", 3'b101, 32'd9, 32'd3, 32'd3, LONG_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
